// File: rtl/c_frag_cfg_pkg.sv
// Shared types and constants for the C_FRAG configuration loader.
// Readback support is enabled by defining C_FRAG_CFG_READBACK_EN.
package c_frag_cfg_pkg;

    localparam logic [7:0] CFG_HDR = 8'hA5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } cfg_state_t;

    // Bit positions of the inverter selects inside each cell byte
    localparam int SEL_TAS1 = 7;
    localparam int SEL_TAS2 = 6;
    localparam int SEL_TBS1 = 5;
    localparam int SEL_TBS2 = 4;
    localparam int SEL_BAS1 = 3;
    localparam int SEL_BAS2 = 2;
    localparam int SEL_BBS1 = 1;
    localparam int SEL_BBS2 = 0;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/c_frag_cfg_readback.sv
// Readback streamer: snapshots the active selects on request and emits
// one byte per cell over a valid/ready handshake, cell 0 first.
module c_frag_cfg_readback
    import c_frag_cfg_pkg::*;
#(
    parameter int NUM_CELLS = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [8*NUM_CELLS-1:0] i_cell_sel,
    input  logic                   i_req,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [7:0]             o_data
);

    localparam int IDXW = idx_width(NUM_CELLS);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_CELLS - 1);

    logic [7:0]      r_snap [NUM_CELLS];
    logic [IDXW-1:0] r_cnt;
    logic            r_valid;
    logic [7:0]      r_data;
    logic            w_start;
    logic [IDXW-1:0] w_cnt_inc;

    // A request while a stream is in flight is ignored
    assign w_start   = i_req && !r_valid;
    assign w_cnt_inc = r_cnt + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CELLS; gi++) begin : g_snap
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_snap[gi] <= 8'h00;
                end else if (w_start) begin
                    r_snap[gi] <= i_cell_sel[gi*8 +: 8];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_data  <= 8'h00;
        end else if (w_start) begin
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_data  <= i_cell_sel[7:0];
        end else if (r_valid && i_ready) begin
            if (r_cnt == IDX_LAST) begin
                r_valid <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_inc;
                r_data <= r_snap[w_cnt_inc];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/c_frag_cfg_loader.sv
// Framed byte-stream loader for the C_FRAG inverter selects with shadow
// copy and atomic commit; optional readback under C_FRAG_CFG_READBACK_EN.
module c_frag_cfg_loader
    import c_frag_cfg_pkg::*;
#(
    parameter int NUM_CELLS = 16
) (
    input  logic                   QCK,
    input  logic                   QRT,
    input  logic                   cfg_valid,
    input  logic [7:0]             cfg_data,
    output logic                   cfg_ready,
    input  logic                   cfg_abort,
    output logic [8*NUM_CELLS-1:0] cell_sel,
    output logic                   done,
    output logic                   err,
    output logic                   busy,
    input  logic                   rb_req,
    output logic                   rb_valid,
    output logic [7:0]             rb_data,
    input  logic                   rb_ready
);

    localparam int IDXW = idx_width(NUM_CELLS);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_CELLS - 1);

    cfg_state_t      r_state;
    cfg_state_t      w_state_next;
    logic [IDXW-1:0] r_idx;
    logic [7:0]      r_xor;
    logic [7:0]      r_shadow   [NUM_CELLS];
    logic [7:0]      r_cell_sel [NUM_CELLS];
    logic            r_done;
    logic            r_err;

    logic w_xfer;
    logic w_start;
    logic w_load_wr;
    logic w_err_set;
    logic w_commit;

    assign cfg_ready = (r_state != COMMIT);
    assign w_xfer    = cfg_valid && cfg_ready;

    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_load_wr    = 1'b0;
        w_err_set    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer && (cfg_data == CFG_HDR)) begin
                    w_state_next = LOAD;
                    w_start      = 1'b1;
                end
            end
            LOAD: begin
                if (w_xfer) begin
                    w_load_wr = 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (w_xfer) begin
                    if (cfg_data == r_xor) begin
                        w_state_next = COMMIT;
                    end else begin
                        w_err_set    = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            COMMIT: begin
                w_commit     = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        // Abort beats any transfer, but a commit already underway completes
        if (cfg_abort && (r_state != COMMIT)) begin
            w_state_next = IDLE;
            w_start      = 1'b0;
            w_load_wr    = 1'b0;
            w_err_set    = 1'b0;
        end
    end

    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            r_idx  <= '0;
            r_xor  <= 8'h00;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_commit;
            r_err  <= w_err_set;
            if (w_start) begin
                r_idx <= '0;
                r_xor <= 8'h00;
            end else if (w_load_wr) begin
                r_idx <= r_idx + 1'b1;
                r_xor <= r_xor ^ cfg_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
            always_ff @(posedge QCK or posedge QRT) begin
                if (QRT) begin
                    r_shadow[gi] <= 8'h00;
                end else if (w_load_wr && (r_idx == IDXW'(gi))) begin
                    r_shadow[gi] <= cfg_data;
                end
            end

            always_ff @(posedge QCK or posedge QRT) begin
                if (QRT) begin
                    r_cell_sel[gi] <= 8'h00;
                end else if (w_commit) begin
                    r_cell_sel[gi] <= r_shadow[gi];
                end
            end

            assign cell_sel[gi*8 +: 8] = r_cell_sel[gi];
        end
    endgenerate

    assign done = r_done;
    assign err  = r_err;
    assign busy = (r_state != IDLE);

`ifdef C_FRAG_CFG_READBACK_EN
    c_frag_cfg_readback #(
        .NUM_CELLS (NUM_CELLS)
    ) u_readback (
        .i_clk      (QCK),
        .i_rst      (QRT),
        .i_cell_sel (cell_sel),
        .i_req      (rb_req),
        .i_ready    (rb_ready),
        .o_valid    (rb_valid),
        .o_data     (rb_data)
    );
`else
    logic w_unused_rb;
    assign w_unused_rb = rb_req ^ rb_ready;
    assign rb_valid    = 1'b0;
    assign rb_data     = 8'h00;
`endif

endmodule

// File: tb/tb_c_frag_cfg_loader.sv
// Directed bench for c_frag_cfg_loader (NUM_CELLS=4) with a scoreboard of
// expected frame outcomes; readback steps run when C_FRAG_CFG_READBACK_EN is set.
module tb_c_frag_cfg_loader;

    localparam int N = 4;

    logic          QCK = 1'b0;
    logic          QRT = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [7:0]    cfg_data = 8'h00;
    logic          cfg_ready;
    logic          cfg_abort = 1'b0;
    logic [8*N-1:0] cell_sel;
    logic          done;
    logic          err;
    logic          busy;
    logic          rb_req = 1'b0;
    logic          rb_valid;
    logic [7:0]    rb_data;
    logic          rb_ready = 1'b0;

    always #5 QCK = ~QCK;

    c_frag_cfg_loader #(.NUM_CELLS(N)) dut (
        .QCK       (QCK),
        .QRT       (QRT),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_abort (cfg_abort),
        .cell_sel  (cell_sel),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .rb_req    (rb_req),
        .rb_valid  (rb_valid),
        .rb_data   (rb_data),
        .rb_ready  (rb_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int done_seen = 0;
    int err_seen  = 0;
    int exp_done  = 0;
    int exp_err   = 0;

    typedef struct packed {
        logic [31:0] sel;
        logic        is_err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_sel = 32'h0;

    always @(posedge QCK) begin
        if (done === 1'b1) done_seen <= done_seen + 1;
        if (err === 1'b1)  err_seen  <= err_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic got;
        got       = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = b;
        for (int k = 0; k < 20 && !got; k++) begin
            got = cfg_ready;
            @(posedge QCK); #1;
        end
        cfg_valid = 1'b0;
        chk("byte_accepted", 32'(got), 32'd1);
    endtask

    // Called right after the checksum handshake (1 time unit past that edge)
    task automatic check_result();
        exp_t e;
        e = sb_q.pop_front();
        if (e.is_err) begin
            chk("err_pulse", 32'(err), 32'd1);
            chk("err_busy_idle", 32'(busy), 32'd0);
            chk("err_sel_kept", cell_sel, e.sel);
            @(posedge QCK); #1;
            chk("err_one_cycle", 32'(err), 32'd0);
        end else begin
            chk("commit_done_early", 32'(done), 32'd0);
            chk("commit_busy", 32'(busy), 32'd1);
            chk("commit_ready_low", 32'(cfg_ready), 32'd0);
            @(posedge QCK); #1;
            chk("done_pulse", 32'(done), 32'd1);
            chk("cell_sel", cell_sel, e.sel);
            chk("no_err", 32'(err), 32'd0);
            chk("idle_after_commit", 32'(busy), 32'd0);
            @(posedge QCK); #1;
            chk("done_one_cycle", 32'(done), 32'd0);
        end
    endtask

    task automatic send_frame(input logic [31:0] pl, input logic [7:0] ck);
        logic [7:0] x;
        exp_t       e;
        x = 8'h00;
        for (int i = 0; i < N; i++) x = x ^ pl[i*8 +: 8];
        if (ck == x) begin
            e.sel    = pl;
            e.is_err = 1'b0;
            model_sel = pl;
            exp_done++;
        end else begin
            e.sel    = model_sel;
            e.is_err = 1'b1;
            exp_err++;
        end
        sb_q.push_back(e);
        send_byte(8'hA5);
        for (int i = 0; i < N; i++) send_byte(pl[i*8 +: 8]);
        send_byte(ck);
        check_result();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge QCK);
        #1;
        chk("rst_cell_sel", cell_sel, 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_rb_valid", 32'(rb_valid), 32'd0);
        chk("rst_rb_data", 32'(rb_data), 32'd0);
        QRT = 1'b0;
        @(posedge QCK); #1;

        // Good frame, then bad checksum
        send_frame(32'h08040201, 8'h0F);
        send_frame(32'h08040201, 8'h0E);

        // Junk before a header is dropped
        send_byte(8'h3C);
        chk("junk1_not_busy", 32'(busy), 32'd0);
        send_byte(8'hFF);
        chk("junk2_not_busy", 32'(busy), 32'd0);
        send_frame(32'h40302010, 8'h40);

        // Abort on the third payload byte
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        cfg_valid = 1'b1;
        cfg_data  = 8'h33;
        cfg_abort = 1'b1;
        @(posedge QCK); #1;
        cfg_valid = 1'b0;
        cfg_abort = 1'b0;
        chk("abort_idle", 32'(busy), 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_no_err", 32'(err), 32'd0);
            chk("abort_sel_kept", cell_sel, model_sel);
            @(posedge QCK); #1;
        end
        send_frame(32'h44332211, 8'h44);

        // A header value inside the payload is plain data
        send_frame(32'h030201A5, 8'hA5);

        // Asynchronous reset while in CHECK
        send_byte(8'hA5);
        for (int i = 0; i < N; i++) send_byte(8'h10 + 8'(i));
        chk("in_check_busy", 32'(busy), 32'd1);
        #2;
        QRT = 1'b1;
        #1;
        chk("async_rst_sel", cell_sel, 32'h0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        model_sel = 32'h0;
        @(negedge QCK);
        QRT = 1'b0;
        @(posedge QCK); #1;
        send_frame(32'h44332211, 8'h44);

`ifdef C_FRAG_CFG_READBACK_EN
        begin
            logic [7:0] rb_q[$];
            rb_q = '{8'h11, 8'h22, 8'h33, 8'h44};
            rb_req = 1'b1;
            @(posedge QCK); #1;
            rb_req = 1'b0;
            fork
                send_frame(32'h88776655, 8'hCC);
                begin
                    for (int k = 0; k < 40 && rb_q.size() > 0; k++) begin
                        rb_ready = (k % 2) == 1;
                        chk("rb_valid", 32'(rb_valid), 32'd1);
                        chk("rb_data", 32'(rb_data), 32'(rb_q[0]));
                        @(posedge QCK); #1;
                        if (rb_ready) void'(rb_q.pop_front());
                    end
                    rb_ready = 1'b0;
                    chk("rb_all_streamed", 32'(rb_q.size()), 32'd0);
                    chk("rb_valid_end", 32'(rb_valid), 32'd0);
                end
            join
        end
`endif

        repeat (2) @(posedge QCK);
        #1;
        chk("done_total", 32'(done_seen), 32'(exp_done));
        chk("err_total", 32'(err_seen), 32'(exp_err));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/c_frag_cfg_loader.md
# c_frag_cfg_loader

Byte-stream configuration writer for an array of C_FRAG logic cells. It accepts a framed configuration stream, checks it, and drives the eight static input-inverter selects of each cell (TAS1, TAS2, TBS1, TBS2, BAS1, BAS2, BBS1, BBS2). The loader writes a shadow copy and commits it atomically, so the fabric never sees a partial frame. It sits between the configuration controller and the logic-cell array.

## Interface
- NUM_CELLS, 16, number of cells configured (1..256)
- QCK  in  1  clock
- QRT  in  1  asynchronous active-high reset
- cfg_valid  in  1  byte valid
- cfg_data  in  8  configuration byte
- cfg_ready  out  1  loader accepts the byte this cycle
- cfg_abort  in  1  synchronous frame abort
- cell_sel  out  8*NUM_CELLS  active selects; byte i = cell i, bit order {TAS1,TAS2,TBS1,TBS2,BAS1,BAS2,BBS1,BBS2} from MSB to LSB
- done  out  1  one-cycle pulse when a commit occurs
- err  out  1  one-cycle pulse on a checksum mismatch
- busy  out  1  high outside IDLE
- rb_req  in  1  readback request pulse
- rb_valid  out  1  readback byte valid
- rb_data  out  8  readback byte
- rb_ready  in  1  readback consumer ready

## Operation
- Frame format: header 0xA5, then NUM_CELLS payload bytes (cell 0 first), then one checksum byte equal to the XOR of all payload bytes.
- A byte transfers on a cycle where cfg_valid and cfg_ready are both high.
- State machine states: IDLE, LOAD, CHECK, COMMIT.
- IDLE:
  - A header byte moves to LOAD and clears idx and the running XOR.
  - Any other byte is consumed and dropped.
- LOAD:
  - Each transferred byte is written to shadow[idx] and XORed into the running XOR; idx increments.
  - The transfer at idx == NUM_CELLS-1 moves to CHECK.
- CHECK:
  - On a byte equal to the running XOR, move to COMMIT.
  - On a mismatch, pulse err, return to IDLE, and leave cell_sel unchanged.
- COMMIT: for exactly one cycle, cell_sel <= shadow, done pulses, then the state returns to IDLE.
- cfg_ready is high in IDLE, LOAD and CHECK, and low in COMMIT.
- cfg_abort forces IDLE on the next edge with no commit and no err. It wins over a simultaneous transfer, and an abort during COMMIT does not cancel that commit.
- A header byte received during LOAD is treated as payload; no resynchronisation takes place inside a frame.
- idx width is max(1, $clog2(NUM_CELLS)). The NUM_CELLS=1 frame is header, 1 byte, checksum.

## Timing
- Reset (QRT high, asynchronous): state IDLE, cell_sel = 0 (matches the cells' default parameters), shadow = 0, done/err/rb_valid = 0, rb_data = 0, busy = 0.
- Reset released mid-frame: the partial frame is lost and cell_sel stays 0.
- Latency: the cycle after the checksum transfer is COMMIT. cell_sel changes and done pulses on the edge at the end of COMMIT, i.e. 2 edges after the checksum handshake.
- err asserts on the edge following the bad checksum transfer.
- Back-to-back frames: a header may transfer in the IDLE cycle directly after COMMIT.
- Minimum frame length is NUM_CELLS+3 cycles including COMMIT.

## Configuration
- Macro: C_FRAG_CFG_READBACK_EN.
- Defined:
  - rb_req (ignored while a readback is in flight) snapshots cell_sel and streams NUM_CELLS bytes, cell 0 first.
  - rb_valid holds until rb_ready; rb_data is stable while rb_valid && !rb_ready.
  - A commit during readback does not alter the snapshot being streamed.
  - The first rb_valid appears 1 cycle after rb_req.
- Undefined: the readback logic is removed, rb_valid = 0, rb_data = 0, and rb_req and rb_ready are ignored. The ports remain.

## Structure
- Package c_frag_cfg_pkg contains:
  - CFG_HDR = 8'hA5
  - state enum cfg_state_t {IDLE, LOAD, CHECK, COMMIT}
  - bit-position constants SEL_TAS1..SEL_BBS2 (7..0)
- Sub-module c_frag_cfg_readback holds the snapshot register, byte counter and valid/ready output stage. It is instantiated only under C_FRAG_CFG_READBACK_EN.

## Test plan
- NUM_CELLS=4, reset then frame A5,01,02,04,08,0F -> done pulses once 2 edges after 0F, cell_sel = 32'h08040201, err never asserts.
- Same frame with checksum 0E -> err pulses once, cell_sel stays at its previous value, state returns to IDLE.
- Bytes 3C,FF before a valid frame -> dropped, no busy; the following frame commits normally.
- cfg_abort asserted on the 3rd payload byte with cfg_valid high -> IDLE, no done, no err; a re-sent full frame commits.
- QRT asserted while in CHECK after a committed frame -> cell_sel = 0 immediately (asynchronous), done = 0; the next frame loads normally.
- With C_FRAG_CFG_READBACK_EN: commit 11,22,33,44, rb_req, rb_ready toggling 1/0, then a new frame committed mid-stream -> rb_data sequence 11,22,33,44 with each byte held while rb_ready=0.
